// File: rtl/spi_target_pkg.sv
// Shared types and constants for the spi_target SPI mode-0 target.
package spi_target_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam logic [BYTE_W-1:0] RX_DATA_RST = 8'h00;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/spi_target_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detection
// taken from the last two synchronized samples.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, MSB-first byte shifting, rx pulse and tx holding register.
// Optional macro SPI_TARGET_ECHO_EN: an empty holding register echoes the last received byte.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_spi_sclk,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    input  logic [BYTE_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [BYTE_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_underrun,
    output logic              o_busy,
    output logic              o_frame_end
);

    logic w_sclk_rise, w_sclk_fall, w_sclk_sync_unused;
    logic w_cs_rise, w_cs_fall, w_cs_sync_unused;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_spi_sclk),
        .o_sync  (w_sclk_sync_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_spi_cs_n),
        .o_sync  (w_cs_sync_unused),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_spi_mosi),
        .o_sync  (w_mosi),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    state_e               r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [BYTE_W-1:0]    r_rx_shift;
    logic [BYTE_W-1:0]    r_tx_shift;
    logic [BYTE_W-1:0]    r_rx_data;
    logic [BYTE_W-1:0]    r_hold;
    logic                 r_hold_full;
    logic                 r_rx_done;
    logic                 r_rx_valid;
    logic                 r_underrun;
    logic                 r_frame_end;
    logic                 r_miso;

    logic                 w_active;
    logic                 w_cs_edge;
    logic                 w_start;
    logic                 w_sclk_rise_act;
    logic                 w_sclk_fall_act;
    logic                 w_byte_load;
    logic                 w_underrun;
    logic [BYTE_W-1:0]    w_load_byte;

    // A cs_n edge masks any sclk edge landing in the same cycle.
    assign w_active        = (r_state == ACTIVE);
    assign w_cs_edge       = w_cs_rise | w_cs_fall;
    assign w_start         = !w_active && w_cs_fall;
    assign w_sclk_rise_act = w_active && !w_cs_edge && w_sclk_rise;
    assign w_sclk_fall_act = w_active && !w_cs_edge && w_sclk_fall;
    assign w_byte_load     = w_start || (w_sclk_fall_act && (r_bit_cnt == '0));

`ifdef SPI_TARGET_ECHO_EN
    assign w_load_byte = r_hold_full ? r_hold : r_rx_data;
    assign w_underrun  = 1'b0;
`else
    assign w_load_byte = r_hold_full ? r_hold : DEFAULT_TX;
    assign w_underrun  = w_byte_load && !r_hold_full;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_rx_done   <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_end <= 1'b0;
            // Only a frame that was actually started reports its end; this also
            // keeps the cs_n settling after reset release from pulsing.
            if (w_cs_rise) begin
                r_state     <= IDLE;
                r_bit_cnt   <= '0;
                r_frame_end <= w_active;
            end else if (w_start) begin
                r_state   <= ACTIVE;
                r_bit_cnt <= '0;
            end else if (w_sclk_rise_act) begin
                r_rx_shift <= {r_rx_shift[BYTE_W-2:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                r_rx_done  <= (r_bit_cnt == '1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_shift <= '0;
            r_miso     <= DEFAULT_TX[BYTE_W-1];
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_underrun;
            if (w_byte_load) begin
                r_tx_shift <= w_load_byte;
                r_miso     <= w_load_byte[BYTE_W-1];
            end else if (w_sclk_fall_act) begin
                r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
                r_miso     <= r_tx_shift[BYTE_W-2];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_data  <= RX_DATA_RST;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= r_rx_done;
            if (r_rx_done) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    // An empty-holding load leaves the register free, so a same-cycle capture lands for the next byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_byte_load && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (i_tx_valid && !r_hold_full) begin
            r_hold      <= i_tx_data;
            r_hold_full <= 1'b1;
        end
    end

    assign o_spi_miso    = r_miso;
    assign o_spi_miso_oe = w_active;
    assign o_busy        = w_active;
    assign o_tx_ready    = !r_hold_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_underrun;
    assign o_frame_end   = r_frame_end;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives an SPI mode-0 master and checks with immediate assertions.
module tb_spi_target;

`ifdef SPI_TARGET_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi, tx_valid;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_ready, rx_valid, underrun, busy, frame_end;
    logic [7:0] rx_data;

    int n_chk = 0;
    int n_err = 0;
    int n_rx = 0, n_und = 0, n_fe = 0;
    int s_rx, s_und, s_fe;
    logic [7:0] rd;

    spi_target dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_spi_sclk    (sclk),
        .i_spi_cs_n    (cs_n),
        .i_spi_mosi    (mosi),
        .o_spi_miso    (miso),
        .o_spi_miso_oe (miso_oe),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .o_tx_underrun (underrun),
        .o_busy        (busy),
        .o_frame_end   (frame_end)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)  n_rx  = n_rx + 1;
        if (underrun)  n_und = n_und + 1;
        if (frame_end) n_fe  = n_fe + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_rx = n_rx; s_und = n_und; s_fe = n_fe;
    endtask

    // nbits MSB-first bits of tx; when last is set, the final sclk fall coincides with cs_n rising.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit last, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            cyc(H);
            r[i] = miso;
            sclk = 1'b1;
            cyc(H);
            sclk = 1'b0;
            if (last && i == 8 - nbits) cs_n = 1'b1;
        end
        cyc(H);
    endtask

    task automatic preload(input logic [7:0] d);
        tx_data = d; tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(4);
        rst_n = 1'b1;
        cyc(6);
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        cyc(4);
        chk("rst_miso", miso, 8'h01);
        chk("rst_oe", miso_oe, 8'h00);
        chk("rst_tx_ready", tx_ready, 8'h01);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_pulses", {rx_valid, underrun, frame_end, busy}, 8'h00);
        rst_n = 1'b1;
        cyc(6);
        chk("post_rst_fe", n_fe, 8'h00);

        // Preloaded A5 out, 3C in.
        preload(8'hA5);
        chk("preload_ready", tx_ready, 8'h00);
        snap();
        cs_n = 1'b0;
        cyc(5);
        chk("busy_in_frame", busy, 8'h01);
        chk("oe_in_frame", miso_oe, 8'h01);
        chk("ready_after_load", tx_ready, 8'h01);
        xfer(8'h3C, 8, 1'b1, rd);
        chk("b1_miso", rd, 8'hA5);
        chk("b1_rx_data", rx_data, 8'h3C);
        chk("b1_rx_valid", n_rx - s_rx, 8'h01);
        chk("b1_frame_end", n_fe - s_fe, 8'h01);
        chk("b1_underrun", n_und - s_und, 8'h00);
        chk("b1_idle", busy, 8'h00);

        // Partial byte discarded.
        snap();
        cs_n = 1'b0;
        cyc(H);
        xfer(8'hFF, 5, 1'b1, rd);
        chk("part_rx_valid", n_rx - s_rx, 8'h00);
        chk("part_frame_end", n_fe - s_fe, 8'h01);
        chk("part_rx_data", rx_data, 8'h3C);
        snap();
        cs_n = 1'b0;
        cyc(H);
        xfer(8'h81, 8, 1'b1, rd);
        chk("after_part_rx", rx_data, 8'h81);
        chk("after_part_vld", n_rx - s_rx, 8'h01);

        // Three bytes with the holding register empty.
        do_reset();
        snap();
        cs_n = 1'b0;
        cyc(H);
        xfer(8'h11, 8, 1'b0, rd);
        chk("m3_rd0", rd, ECHO ? 8'h00 : 8'hFF);
        chk("m3_rx0", rx_data, 8'h11);
        xfer(8'h22, 8, 1'b0, rd);
        chk("m3_rd1", rd, ECHO ? 8'h11 : 8'hFF);
        xfer(8'h33, 8, 1'b1, rd);
        chk("m3_rd2", rd, ECHO ? 8'h22 : 8'hFF);
        chk("m3_rx2", rx_data, 8'h33);
        chk("m3_rx_valid", n_rx - s_rx, 8'h03);
        chk("m3_underrun", n_und - s_und, ECHO ? 8'h00 : 8'h03);
        chk("m3_frame_end", n_fe - s_fe, 8'h01);

        // Reset mid-byte with cs_n held low.
        preload(8'h77);
        cs_n = 1'b0;
        cyc(H);
        xfer(8'hF0, 3, 1'b0, rd);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", miso, 8'h01);
        chk("mid_rst_oe", miso_oe, 8'h00);
        chk("mid_rst_busy", busy, 8'h00);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        chk("mid_rst_ready", tx_ready, 8'h01);
        cyc(4);
        rst_n = 1'b1;
        snap();
        xfer(8'hC3, 8, 1'b0, rd);
        chk("locked_rx_valid", n_rx - s_rx, 8'h00);
        chk("locked_busy", busy, 8'h00);
        chk("locked_rx_data", rx_data, 8'h00);
        cs_n = 1'b1;
        cyc(H);
        chk("locked_frame_end", n_fe - s_fe, 8'h00);
        snap();
        cs_n = 1'b0;
        cyc(H);
        xfer(8'h5A, 8, 1'b1, rd);
        chk("fresh_miso", rd, ECHO ? 8'h00 : 8'hFF);
        chk("fresh_rx_data", rx_data, 8'h5A);
        chk("fresh_rx_valid", n_rx - s_rx, 8'h01);
        chk("fresh_frame_end", n_fe - s_fe, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
